pc_watchpoint_unit: RTL

Parametrised, multi-channel successor to the fixed 12-bit equality comparator. Compares a stream of addresses (PC or data address) against CHANNELS programmable watchpoints. Each channel has a per-bit compare mask, a hit-skip counter and one-shot arming. Sits beside the fetch/memory stage and raises a halt request to the pipeline controller, held until acknowledged.

---
 rtl/pc_watchpoint_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pc_watchpoint_unit.sv
// Multi-channel address watchpoint unit: per-channel masked compare, skip counter and
// one-shot arming, feeding a two-state halt request held until the controller acknowledges.
module pc_watchpoint_unit #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int CH_W     = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic                cfg_en,
  input  logic [WIDTH-1:0]    cfg_addr,
  input  logic [WIDTH-1:0]    cfg_mask,
  input  logic [CNT_W-1:0]    cfg_count,
  input  logic                addr_valid,
  input  logic [WIDTH-1:0]    addr,
  input  logic                halt_ack,
  input  logic                sticky_clr,
  output logic                hit_valid,
  output logic [CHANNELS-1:0] hit_vec,
  output logic [CHANNELS-1:0] sticky,
  output logic                halt_req
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HALT = 1'b1
  } state_e;

  logic [CHANNELS-1:0]            en_q, en_d;
  logic [CHANNELS-1:0][WIDTH-1:0] addr_q, addr_d;
  logic [CHANNELS-1:0][WIDTH-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0][CNT_W-1:0] count_q, count_d;
  logic [CHANNELS-1:0]            sticky_q, sticky_d;
  logic [CHANNELS-1:0]            hit_vec_q;
  logic                           hit_valid_q;
  logic                           halt_req_q;
  state_e                         state_q;

  logic [CHANNELS-1:0]            cfg_sel_s;
  logic [CHANNELS-1:0]            match_s;
  logic [CHANNELS-1:0]            fire_s;
  logic                           any_fire_s;

  // A mask bit of 0 turns the corresponding address bit into a don't-care.
  function automatic logic masked_match(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] ref_a,
                                        input logic [WIDTH-1:0] mask);
    return &((a ~^ ref_a) | ~mask);
  endfunction

  // Per-channel match, with a same-cycle config write on a channel suppressing its match.
  always_comb begin
    cfg_sel_s = '0;
    match_s   = '0;
    fire_s    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cfg_sel_s[c] = cfg_we && (cfg_ch == CH_W'(c));
      match_s[c]   = en_q[c] && addr_valid && masked_match(addr, addr_q[c], mask_q[c])
                     && !cfg_sel_s[c];
      fire_s[c]    = match_s[c] && (count_q[c] == '0);
    end
    any_fire_s = |fire_s;
  end

  // Channel register next state: config load, one-shot disarm on fire, or skip decrement.
  always_comb begin
    en_d    = en_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    count_d = count_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cfg_sel_s[c]) begin
        en_d[c]    = cfg_en;
        addr_d[c]  = cfg_addr;
        mask_d[c]  = cfg_mask;
        count_d[c] = cfg_count;
      end else if (fire_s[c]) begin
        en_d[c]    = 1'b0;
      end else if (match_s[c]) begin
        count_d[c] = count_q[c] - CNT_W'(1);
      end else begin
        count_d[c] = count_q[c];
      end
    end
    // A fire in the clearing cycle keeps that channel's flag set.
    if (sticky_clr) begin
      sticky_d = fire_s;
    end else begin
      sticky_d = sticky_q | fire_s;
    end
  end

  // Channel configuration and per-cycle hit reporting registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q        <= '0;
      addr_q      <= '0;
      mask_q      <= '0;
      count_q     <= '0;
      sticky_q    <= '0;
      hit_vec_q   <= '0;
      hit_valid_q <= 1'b0;
    end else begin
      en_q        <= en_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      sticky_q    <= sticky_d;
      hit_vec_q   <= match_s;
      hit_valid_q <= addr_valid;
    end
  end

  // Halt handshake: a fire always wins over a coincident acknowledge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      halt_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_fire_s) begin
            state_q    <= HALT;
            halt_req_q <= 1'b1;
          end else begin
            state_q    <= IDLE;
            halt_req_q <= 1'b0;
          end
        end
        HALT: begin
          if (halt_ack && !any_fire_s) begin
            state_q    <= IDLE;
            halt_req_q <= 1'b0;
          end else begin
            state_q    <= HALT;
            halt_req_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          halt_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit_vec   = hit_vec_q;
  assign sticky    = sticky_q;
  assign halt_req  = halt_req_q;

endmodule
